// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one pulse-request memory port between IFU and LSU
// Optional round-robin tie-break selected by MEM_ARB_RR_EN (fixed LSU priority otherwise).
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_rvalid,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req,
    input  logic            lsu_wen,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_rvalid,
    output logic [DW-1:0]   lsu_rdata,
    input  logic            flush,
    output logic            mem_req,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_nx;
    logic            ifu_pend, lsu_pend;
    logic            owner_lsu;
    logic            drop;
    logic [AW-1:0]   ifu_addr_q;
    logic            lsu_wen_q;
    logic [AW-1:0]   lsu_addr_q;
    logic [DW-1:0]   lsu_wdata_q;
    logic [MW-1:0]   lsu_wmask_q;
    logic            grant_ifu, grant_lsu;

    logic ifu_inflight, lsu_inflight, ifu_cap, lsu_cap, ifu_pend_eff;

    assign ifu_inflight = (state != IDLE) && !owner_lsu;
    assign lsu_inflight = (state != IDLE) && owner_lsu;
    // A flush retires older IFU traffic, so a same-cycle ifu_req is always a fresh request.
    assign ifu_cap      = ifu_req && (flush || !(ifu_pend || ifu_inflight));
    assign lsu_cap      = lsu_req && !(lsu_pend || lsu_inflight);
    assign ifu_pend_eff = ifu_pend && !flush;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_lsu <= 1'b0;
        else if (grant_lsu)
            last_lsu <= 1'b1;
        else if (grant_ifu)
            last_lsu <= 1'b0;
    end
`endif

    always_comb begin
        state_nx  = state;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        case (state)
            IDLE: begin
                if (lsu_pend && ifu_pend_eff) begin
`ifdef MEM_ARB_RR_EN
                    grant_lsu = !last_lsu;
                    grant_ifu = last_lsu;
`else
                    grant_lsu = 1'b1;
`endif
                end else begin
                    grant_lsu = lsu_pend;
                    grant_ifu = ifu_pend_eff;
                end
                if (grant_lsu || grant_ifu)
                    state_nx = ISSUE;
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    if (mem_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_pend    <= 1'b0;
            lsu_pend    <= 1'b0;
            ifu_addr_q  <= '0;
            lsu_wen_q   <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
            lsu_wmask_q <= '0;
        end else begin
            if (ifu_cap) begin
                ifu_pend   <= 1'b1;
                ifu_addr_q <= ifu_addr;
            end else if (flush || grant_ifu) begin
                ifu_pend <= 1'b0;
            end
            if (lsu_cap) begin
                lsu_pend    <= 1'b1;
                lsu_wen_q   <= lsu_wen;
                lsu_addr_q  <= lsu_addr;
                lsu_wdata_q <= lsu_wdata;
                lsu_wmask_q <= lsu_wen ? lsu_wmask : '0;
            end else if (grant_lsu) begin
                lsu_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            owner_lsu <= 1'b0;
            drop      <= 1'b0;
        end else begin
            mem_req <= grant_lsu || grant_ifu;
            if (grant_lsu) begin
                mem_wen   <= lsu_wen_q;
                mem_addr  <= lsu_addr_q;
                mem_wdata <= lsu_wdata_q;
                mem_wmask <= lsu_wmask_q;
                owner_lsu <= 1'b1;
                drop      <= 1'b0;
            end else if (grant_ifu) begin
                mem_wen   <= 1'b0;
                mem_addr  <= ifu_addr_q;
                mem_wdata <= '0;
                mem_wmask <= '0;
                owner_lsu <= 1'b0;
                drop      <= 1'b0;
            end else if (flush && ifu_inflight) begin
                drop <= 1'b1;
            end
        end
    end

    // The memory side still completes a flushed fetch; only its response is hidden.
    assign ifu_rvalid = mem_rvalid && (state == WAIT) && !owner_lsu && !drop && !flush;
    assign lsu_rvalid = mem_rvalid && (state == WAIT) && owner_lsu;
    assign ifu_rdata  = mem_rdata;
    assign lsu_rdata  = mem_rdata;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, lsu_req, lsu_wen, flush, mem_rvalid;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [3:0]  lsu_wmask;
    logic        ifu_rvalid, lsu_rvalid, mem_req, mem_wen, busy;
    logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .flush(flush), .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_t;

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] data;
    } rsp_t;

    mem_t mq[$];
    rsp_t rq[$];
    mem_t cur;
    logic have_cur = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                if (mq.size() == 0) begin
                    chk("mem_req_unexpected", 72'd1, 72'd0);
                end else begin
                    cur = mq.pop_front();
                    have_cur = 1'b1;
                    chk("mem_fields", {mem_wen, mem_addr, mem_wdata, mem_wmask}, cur);
                end
            end else if (busy && have_cur) begin
                chk("mem_fields_held", {mem_wen, mem_addr, mem_wdata, mem_wmask}, cur);
            end
            if (ifu_rvalid && lsu_rvalid)
                chk("both_rvalid", 72'd1, 72'd0);
            if (ifu_rvalid || lsu_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {lsu_rvalid, ifu_rvalid}, 72'd0);
                end else begin
                    rsp_t e;
                    e = rq.pop_front();
                    chk("rsp_owner", {ifu_rvalid, lsu_rvalid}, {!e.is_lsu, e.is_lsu});
                    chk("rsp_data", lsu_rvalid ? lsu_rdata : ifu_rdata, e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_mem(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mq.push_back('{wen: w, addr: a, wdata: d, wmask: m});
    endtask

    task automatic exp_rsp(input logic l, input logic [31:0] d);
        rq.push_back('{is_lsu: l, data: d});
    endtask

    task automatic lsu_set(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        lsu_req = 1'b1; lsu_wen = w; lsu_addr = a; lsu_wdata = d; lsu_wmask = m;
    endtask

    task automatic ifu_pulse(input logic [31:0] a);
        ifu_req = 1'b1; ifu_addr = a;
        tick;
        ifu_req = 1'b0;
    endtask

    task automatic lsu_pulse(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        lsu_set(w, a, d, m);
        tick;
        lsu_req = 1'b0;
    endtask

    task automatic wait_req;
        int n = 0;
        while (!mem_req && n < 40) begin
            tick;
            n++;
        end
        if (!mem_req) chk("mem_req_timeout", 72'd0, 72'd1);
    endtask

    task automatic respond(input int d, input logic [31:0] data);
        repeat (d) tick;
        mem_rvalid = 1'b1; mem_rdata = data;
        tick;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ifu_req = 1'b0; lsu_req = 1'b0; lsu_wen = 1'b0; flush = 1'b0;
        mem_rvalid = 1'b0; ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_rdata = '0;
        tick; tick;
        chk("reset_outputs", {busy, mem_req, mem_wen, ifu_rvalid, lsu_rvalid}, 72'd0);
        chk("reset_fields", {mem_addr, mem_wdata, mem_wmask}, 72'd0);
        rst = 1'b0;
        tick; tick;

        // single IFU read with exact latency
        exp_mem(1'b0, 32'h3000_0000, 32'h0, 4'h0);
        exp_rsp(1'b0, 32'h0000_0413);
        ifu_pulse(32'h3000_0000);
        chk("ifu_no_req_at_pending", mem_req, 0);
        tick;
        chk("ifu_req_latency", mem_req, 1);
        tick;
        chk("mem_req_one_cycle", {mem_req, busy}, 72'b01);
        respond(2, 32'h0000_0413);
        chk("ifu_done_idle", busy, 0);
        tick;

        // tie after IFU was granted last: LSU first in both policies
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0);
        exp_mem(1'b0, 32'h200, 32'h0, 4'h0);
        exp_rsp(1'b1, 32'hA1);
        exp_rsp(1'b0, 32'hB2);
        ifu_req = 1'b1; ifu_addr = 32'h200;
        lsu_set(1'b0, 32'h100, 32'h0, 4'h0);
        tick;
        ifu_req = 1'b0; lsu_req = 1'b0;
        wait_req;
        respond(2, 32'hA1);
        chk("tie_gap_idle", mem_req, 0);
        tick;
        chk("tie_second_grant", mem_req, 1);
        respond(2, 32'hB2);
        tick;

        // LSU store
        exp_mem(1'b1, 32'h0F00_0004, 32'hDEAD_BEEF, 4'hF);
        exp_rsp(1'b1, 32'h5A5A_5A5A);
        lsu_pulse(1'b1, 32'h0F00_0004, 32'hDEAD_BEEF, 4'hF);
        wait_req;
        respond(3, 32'h5A5A_5A5A);
        tick;

        // second tie after LSU was granted last
`ifdef MEM_ARB_RR_EN
        exp_mem(1'b0, 32'h280, 32'h0, 4'h0);
        exp_mem(1'b1, 32'h180, 32'h1122_3344, 4'h3);
        exp_rsp(1'b0, 32'hC3);
        exp_rsp(1'b1, 32'hD4);
`else
        exp_mem(1'b1, 32'h180, 32'h1122_3344, 4'h3);
        exp_mem(1'b0, 32'h280, 32'h0, 4'h0);
        exp_rsp(1'b1, 32'hC3);
        exp_rsp(1'b0, 32'hD4);
`endif
        ifu_req = 1'b1; ifu_addr = 32'h280;
        lsu_set(1'b1, 32'h180, 32'h1122_3344, 4'h3);
        tick;
        ifu_req = 1'b0; lsu_req = 1'b0;
        wait_req;
        respond(2, 32'hC3);
        wait_req;
        respond(2, 32'hD4);
        tick;

        // flush during IFU WAIT with an LSU load arriving
        exp_mem(1'b0, 32'h400, 32'h0, 4'h0);
        exp_mem(1'b0, 32'h500, 32'h0, 4'h0);
        exp_rsp(1'b1, 32'hE5);
        ifu_pulse(32'h400);
        wait_req;
        tick;
        flush = 1'b1;
        lsu_set(1'b0, 32'h500, 32'h0, 4'h0);
        tick;
        flush = 1'b0; lsu_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hF00D;
        chk("flush_drops_ifu_rvalid", {ifu_rvalid, lsu_rvalid}, 72'd0);
        tick;
        mem_rvalid = 1'b0;
        chk("flush_back_idle", busy, 0);
        tick;
        chk("lsu_after_flush", mem_req, 1);
        respond(2, 32'hE5);
        tick;

        // reset asserted in WAIT, then a stray completion
        exp_mem(1'b0, 32'h600, 32'h0, 4'h0);
        ifu_pulse(32'h600);
        wait_req;
        tick;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {busy, mem_req, mem_wen, ifu_rvalid, lsu_rvalid}, 72'd0);
        chk("rst_mid_fields", {mem_addr, mem_wdata, mem_wmask}, 72'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h6666;
        tick;
        rst = 1'b0;
        #1;
        chk("stray_rvalid_ignored", {busy, ifu_rvalid, lsu_rvalid}, 72'd0);
        tick;
        mem_rvalid = 1'b0;
        tick;

        // duplicate LSU requests while pending and while in flight
        exp_mem(1'b0, 32'h700, 32'h0, 4'h0);
        exp_rsp(1'b1, 32'h77);
        lsu_set(1'b0, 32'h700, 32'h0, 4'h0);
        tick;
        lsu_set(1'b1, 32'h999, 32'hFFFF, 4'hF);
        tick;
        lsu_req = 1'b0;
        wait_req;
        tick;
        lsu_pulse(1'b0, 32'h888, 32'h0, 4'h0);
        respond(1, 32'h77);
        repeat (10) tick;

        chk("mem_queue_drained", mq.size(), 0);
        chk("rsp_queue_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
